// File: rtl/free_list_new.sv
// ============================================================================
// Module   : free_list_new
// Brief    : Physical-register free list, 32-entry circular FIFO of 6-bit tags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module free_list_new (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] PR_old,
    input  logic       retire_reg,
    input  logic       RegDest,
    input  logic       stall_recover,
    input  logic       hazard_stall,
    input  logic       recover,
    input  logic [5:0] PR_new_flush,
    input  logic       RegDest_ROB,
    output logic [5:0] PR_new,
    output logic       empty
);

    localparam int c_DEPTH = 32;

    logic [5:0] r_mem [0:c_DEPTH-1];
    logic [4:0] r_head;
    logic [4:0] r_tail;
    logic [5:0] r_count;

    logic       w_pop;
    logic       w_req_r;
    logic       w_req_f;
    logic       w_push_r;
    logic       w_push_f;
    logic [6:0] w_room;
    logic [4:0] w_tail_f;

    assign empty  = (r_count == 6'd0);
    assign PR_new = r_mem[r_head];

    assign w_pop   = RegDest & ~empty & ~hazard_stall & ~stall_recover & ~recover;
    assign w_req_r = retire_reg & ~hazard_stall;
    assign w_req_f = recover & RegDest_ROB;

    // Free slots after this cycle's pop; the retire port claims space first.
    assign w_room   = 7'd32 - {1'b0, r_count} + {6'd0, w_pop};
    assign w_push_r = w_req_r & (w_room >= 7'd1);
    assign w_push_f = w_req_f & (w_room >= (w_push_r ? 7'd2 : 7'd1));
    assign w_tail_f = w_push_r ? (r_tail + 5'd1) : r_tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 6'(c_DEPTH + i);
            end
            r_head  <= 5'd0;
            r_tail  <= 5'd0;
            r_count <= 6'd32;
        end else begin
            if (w_push_r) begin
                r_mem[r_tail] <= PR_old;
            end
            if (w_push_f) begin
                r_mem[w_tail_f] <= PR_new_flush;
            end
            r_tail  <= r_tail + {4'd0, w_push_r} + {4'd0, w_push_f};
            r_head  <= r_head + {4'd0, w_pop};
            r_count <= r_count + {5'd0, w_push_r} + {5'd0, w_push_f} - {5'd0, w_pop};
        end
    end

`ifdef FREE_LIST_OVERFLOW_ASSERT
    // A dropped push means a PR was lost somewhere upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_req_r && !w_push_r) && !(w_req_f && !w_push_f))
                else $error("free_list_new: push dropped on full list");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list_new.sv
// ============================================================================
// Module   : tb_free_list_new
// Brief    : Directed scoreboard bench for free_list_new.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_free_list_new;

    logic       clk;
    logic       rst;
    logic [5:0] PR_old;
    logic       retire_reg;
    logic       RegDest;
    logic       stall_recover;
    logic       hazard_stall;
    logic       recover;
    logic [5:0] PR_new_flush;
    logic       RegDest_ROB;
    logic [5:0] PR_new;
    logic       empty;

    free_list_new dut (
        .clk           (clk),
        .rst           (rst),
        .PR_old        (PR_old),
        .retire_reg    (retire_reg),
        .RegDest       (RegDest),
        .stall_recover (stall_recover),
        .hazard_stall  (hazard_stall),
        .recover       (recover),
        .PR_new_flush  (PR_new_flush),
        .RegDest_ROB   (RegDest_ROB),
        .PR_new        (PR_new),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] pr;
        logic       emp;
        logic [5:0] cnt;
        logic       chk_pr;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: one expectation per clock edge, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ((e.chk_pr && (PR_new !== e.pr)) || (empty !== e.emp) ||
                    (dut.r_count !== e.cnt)) begin
                    n_err++;
                    $display("FAIL %s: got PR_new=%0d empty=%0b count=%0d, want PR_new=%0d empty=%0b count=%0d",
                             e.name, PR_new, empty, dut.r_count, e.pr, e.emp, e.cnt);
                end
            end
        end
    end

    task automatic cyc(input logic rd, input logic rr, input logic [5:0] old,
                       input logic sr, input logic hs, input logic rc,
                       input logic [5:0] fl, input logic rob, input logic rstv,
                       input logic [5:0] xpr, input logic xemp, input logic [5:0] xcnt,
                       input logic xchk, input string nm);
        exp_t e;
        @(negedge clk);
        RegDest       = rd;
        retire_reg    = rr;
        PR_old        = old;
        stall_recover = sr;
        hazard_stall  = hs;
        recover       = rc;
        PR_new_flush  = fl;
        RegDest_ROB   = rob;
        rst           = rstv;
        e.pr = xpr; e.emp = xemp; e.cnt = xcnt; e.chk_pr = xchk; e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        logic [5:0] tail4 [4];
        int         wait_cnt;
        tail4 = '{6'd1, 6'd12, 6'd4, 6'd7};
        rst = 1'b0; RegDest = 1'b0; retire_reg = 1'b0; PR_old = 6'd0;
        stall_recover = 1'b0; hazard_stall = 1'b0; recover = 1'b0;
        PR_new_flush = 6'd0; RegDest_ROB = 1'b0;
        repeat (2) @(negedge clk);

        //    rd  rr  old  sr  hs  rc  fl  rob rst   pr  emp cnt chk
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd32, 0, 6'd32, 1, "reset");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'd33, 0, 6'd31, 1, "pop1");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'd34, 0, 6'd30, 1, "pop2");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'd35, 0, 6'd29, 1, "pop3");
        cyc(1, 1, 6'd1, 0, 0, 0, 0, 0, 1, 6'd36, 0, 6'd29, 1, "pop_retire");
        cyc(1, 0, 0, 1, 0, 0, 6'd3, 1, 1, 6'd36, 0, 6'd29, 1, "stall_recover");
        cyc(1, 1, 6'd12, 0, 0, 1, 6'd4, 1, 1, 6'd36, 0, 6'd31, 1, "retire_flush");
        cyc(1, 0, 0, 0, 0, 1, 6'd5, 0, 1, 6'd36, 0, 6'd31, 1, "flush_nodest");
        cyc(1, 1, 6'd7, 0, 1, 0, 0, 0, 1, 6'd36, 0, 6'd31, 1, "hazard1");
        cyc(1, 1, 6'd7, 0, 1, 0, 0, 0, 1, 6'd36, 0, 6'd31, 1, "hazard2");
        cyc(1, 1, 6'd7, 0, 0, 0, 0, 0, 1, 6'd37, 0, 6'd31, 1, "hazard_release");

        for (int k = 1; k <= 26; k++)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'(37 + k), 0, 6'(31 - k), 1, "drain_init");
        for (int k = 0; k < 4; k++)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, tail4[k], 0, 6'(4 - k), 1, "drain_returned");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'd0, 1, 6'd0, 0, "to_empty");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'd0, 1, 6'd0, 0, "pop_on_empty");

        for (int k = 0; k < 32; k++)
            cyc(0, 1, 6'(16 + k), 0, 0, 0, 0, 0, 1, 6'd16, 0, 6'(k + 1), 1, "fill");
        cyc(0, 1, 6'd55, 0, 0, 0, 0, 0, 1, 6'd16, 0, 6'd32, 1, "overflow_retire");
        cyc(0, 1, 6'd56, 0, 0, 1, 6'd57, 1, 1, 6'd16, 0, 6'd32, 1, "overflow_both");

        for (int k = 1; k < 32; k++)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'(16 + k), 0, 6'(32 - k), 1, "drain_fill");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'd0, 1, 6'd0, 0, "drain_fill_empty");

        cyc(1, 1, 6'd9, 0, 0, 0, 0, 0, 1, 6'd9, 0, 6'd1, 1, "push_before_reset");
        cyc(1, 1, 6'd9, 0, 0, 0, 0, 0, 0, 6'd32, 0, 6'd32, 1, "mid_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd32, 0, 6'd32, 1, "after_reset");

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
